// File: rtl/display_pkg.sv
// display_pkg: segment codes, BCD/digit-index types and the digit-to-segment decoder
package display_pkg;
    typedef logic [3:0] bcd_t;
    typedef logic [1:0] digit_idx_t;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    function automatic logic [6:0] seg_decode(bcd_t d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction
endpackage

// File: rtl/display_multiplexer_if.sv
// display_multiplexer_if: value-in / segment-bus-out signals between datapath and display driver
interface display_multiplexer_if;
    logic [11:0] sum_result;
    logic [6:0]  segments;
    logic [3:0]  display_select;
    modport master (output sum_result, input segments, input display_select);
    modport slave  (input sum_result, output segments, output display_select);
endinterface

// File: rtl/display_multiplexer_bin_to_bcd.sv
// bin_to_bcd: combinational double-dabble of a 12-bit binary value into four BCD digits
module bin_to_bcd
    import display_pkg::*;
(
    input  logic [11:0] i_bin,
    output bcd_t        o_units,
    output bcd_t        o_tens,
    output bcd_t        o_hundreds,
    output bcd_t        o_thousands
);
    logic [27:0] w_s;
    // shift-add-3: bump any BCD nibble above 4 before each left shift
    always_comb begin
        w_s = {16'd0, i_bin};
        for (int i = 0; i < 12; i++) begin
            for (int d = 0; d < 4; d++)
                if (w_s[12+4*d +: 4] > 4'd4) w_s[12+4*d +: 4] = w_s[12+4*d +: 4] + 4'd3;
            w_s = w_s << 1;
        end
    end
    assign o_units     = w_s[15:12];
    assign o_tens      = w_s[19:16];
    assign o_hundreds  = w_s[23:20];
    assign o_thousands = w_s[27:24];
endmodule

// File: rtl/display_multiplexer.sv
// display_multiplexer: BCD digit registers plus 4-digit scan onto a shared 7-segment bus
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits (units always lit).
module display_multiplexer
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    display_multiplexer_if.slave  bus
);
    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
    bcd_t w_units, w_tens, w_hundreds, w_thousands, w_digit;
    bcd_t units, tens, hundreds, thousands;
    logic [CW-1:0] r_cnt;
    digit_idx_t    r_idx;
    logic [6:0]    r_seg;
    logic [3:0]    r_sel;
    logic          w_blank;
    bin_to_bcd u_bin_to_bcd (
        .i_bin       (bus.sum_result),
        .o_units     (w_units),
        .o_tens      (w_tens),
        .o_hundreds  (w_hundreds),
        .o_thousands (w_thousands)
    );
    // sample the converted input every cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            units     <= '0;
            tens      <= '0;
            hundreds  <= '0;
            thousands <= '0;
        end else begin
            units     <= w_units;
            tens      <= w_tens;
            hundreds  <= w_hundreds;
            thousands <= w_thousands;
        end
    end
    // dwell counter; digit index advances once per REFRESH_DIV cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
    assign w_digit = (r_idx == 2'd0) ? units :
                     (r_idx == 2'd1) ? tens :
                     (r_idx == 2'd2) ? hundreds : thousands;
`ifdef LEADING_ZERO_BLANK_EN
    assign w_blank = (r_idx == 2'd3 && thousands == 4'd0) ||
                     (r_idx == 2'd2 && {thousands, hundreds} == 8'd0) ||
                     (r_idx == 2'd1 && {thousands, hundreds, tens} == 12'd0);
`else
    assign w_blank = 1'b0;
`endif
    // segments and select are registered together so they always switch on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg <= SEG_BLANK;
            r_sel <= 4'b1111;
        end else begin
            r_seg <= w_blank ? SEG_BLANK : seg_decode(w_digit);
            r_sel <= ~(4'b0001 << r_idx);
        end
    end
    assign bus.segments       = r_seg;
    assign bus.display_select = r_sel;
endmodule

// File: tb/tb_display_multiplexer.sv
// tb_display_multiplexer: random and directed values checked against a decimal-arithmetic display model
module tb_display_multiplexer;
    localparam int DIV = 4;
    localparam logic [6:0] SEGTAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic clk = 1'b0;
    logic reset;
    int vectors = 0;
    int errors = 0;
    int n = 0;
    int reg_val = 0;
    int cur = 0;
    display_multiplexer_if bus();
    display_multiplexer #(.REFRESH_DIV(DIV)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    function automatic int pow10(int i);
        return (i == 0) ? 1 : (i == 1) ? 10 : (i == 2) ? 100 : 1000;
    endfunction
    function automatic logic [6:0] exp_seg(int v, int idx);
`ifdef LEADING_ZERO_BLANK_EN
        if (idx > 0 && v < pow10(idx)) return 7'h7F;
`endif
        return SEGTAB[(v / pow10(idx)) % 10];
    endfunction
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h (value %0d, edge %0d)", tag, got, exp, reg_val, n);
        end
    endtask
    task automatic tick();
        int idx;
        logic [6:0] es;
        logic [3:0] esel;
        @(posedge clk);
        n++;
        idx = ((n - 1) / DIV) % 4;
        es = exp_seg(reg_val, idx);
        esel = ~(4'b0001 << idx);
        reg_val = cur;
        @(negedge clk);
        chk("segments", bus.segments, es);
        chk("select", bus.display_select, esel);
        chk("units", dut.units, reg_val % 10);
        chk("tens", dut.tens, (reg_val / 10) % 10);
        chk("hundreds", dut.hundreds, (reg_val / 100) % 10);
        chk("thousands", dut.thousands, reg_val / 1000);
    endtask
    task automatic apply(input int v);
        cur = v;
        bus.sum_result = 12'(v);
        repeat (4 * DIV + 2) tick();
    endtask
    initial begin
        reset = 1'b1;
        bus.sum_result = '0;
        repeat (2) @(negedge clk);
        chk("reset_seg", bus.segments, 7'h7F);
        chk("reset_sel", bus.display_select, 4'b1111);
        reset = 1'b0;
        n = 0;
        reg_val = 0;
        apply(2441);
        apply(567);
        apply(34);
        apply(5);
        apply(4095);
        apply(0);
        apply(1000);
        apply(99);
        for (int k = 0; k < 6; k++) apply(int'($urandom_range(0, 4095)));
        cur = 1234;
        bus.sum_result = 12'd1234;
        for (int k = 0; k < 16 && !(dut.r_idx == 2'd2 && (n % DIV) == 1); k++) tick();
        chk("reached_idx2", dut.r_idx, 2'd2);
        reset = 1'b1;
        #1;
        chk("midreset_seg", bus.segments, 7'h7F);
        chk("midreset_sel", bus.display_select, 4'b1111);
        chk("midreset_units", dut.units, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        reg_val = 0;
        repeat (4 * DIV + 2) tick();
        apply(int'($urandom_range(0, 4095)));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/display_multiplexer.md
# display_multiplexer

Converts a 12-bit unsigned binary result into four BCD digits and time-multiplexes them onto one shared 7-segment bus with a 4-bit digit select. It sits at the output stage of the multiplier/adder datapath and drives a 4-digit common-anode display directly. All four BCD digits are registered internally so the display can scan them.

## Interface
- REFRESH_DIV, default 50000: clock cycles each digit stays selected; minimum 2.
- clk  input  1  system clock; single clock domain.
- reset  input  1  asynchronous, active-high; clears all state.
- sum_result  input  12  unsigned binary value to display, 0..4095.
- segments  output  7  {g,f,e,d,c,b,a}, active-low.
- display_select  output  4  active-low one-hot digit enable; bit0 units, bit1 tens, bit2 hundreds, bit3 thousands.
- Internal registers named units, tens, hundreds and thousands, each 4 bits, must exist at the top level of the block for hierarchical probing.

## Operation
- Binary-to-BCD conversion uses combinational double-dabble (shift-add-3) over the 12 input bits, producing 16 BCD bits.
- On every clk edge, units, tens, hundreds and thousands register the conversion result. There is no load strobe; the input is sampled continuously.
- thousands is always 0..4. Every digit is 0..9.
- A scan counter counts 0..REFRESH_DIV-1 and wraps. On each wrap, a 2-bit digit index advances 0→1→2→3→0.
- A digit mux selects units, tens, hundreds or thousands by index.
- A decoder maps the selected digit to active-low segments:
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - Codes 10..15 give blank (7'h7F).
- display_select is the index decoded to active-low one-hot: index 0 gives 4'b1110, index 3 gives 4'b0111.

## Timing
- Reset asserted: digits are 0, counter is 0, index is 0, segments is 7'h7F and display_select is 4'b1111. Reset takes effect immediately and asynchronously.
- After reset deasserts, the first clk edge loads the digit registers. segments and display_select are registered and show index 0 (units) from that edge onward.
- BCD latency: a sum_result change is visible in the digit registers after exactly 1 clk edge.
- Segment latency: a digit change is visible on segments after 1 more edge, provided that digit is currently selected.
- Each digit is shown for exactly REFRESH_DIV cycles. A full frame is 4×REFRESH_DIV cycles.
- Exactly one display_select bit is low at any time outside reset.
- segments and display_select change on the same edge, so there is no ghosting from mismatched updates.
- Asserting reset mid-scan returns to index 0 and clears the counter. Scanning restarts on units.
- A sum_result change mid-frame is not held off. Later digits in the same frame show the new value.

## Configuration
- LEADING_ZERO_BLANK_EN defined: leading zero digits are blanked (segments 7'h7F) while the digit is still selected in turn.
  - thousands blanks when it is 0.
  - hundreds blanks when thousands and hundreds are both 0.
  - tens blanks when thousands, hundreds and tens are all 0.
  - units is never blanked, so a value of 0 shows "0".
- LEADING_ZERO_BLANK_EN undefined: all four digits always display, including leading zeros.

## Structure
- Package display_pkg holds:
  - the SEG_0..SEG_9 and SEG_BLANK active-low constants;
  - a bcd_t 4-bit typedef;
  - a digit_idx_t 2-bit typedef.
- One sub-module, bin_to_bcd: purely combinational, 12-bit input, four bcd_t outputs. The top level holds the registers, scan counter, mux and decoder.

## Test plan
Benches run with REFRESH_DIV=4.
- Reset asserted → segments=7'h7F and display_select=4'b1111. After release → display_select=4'b1110.
- sum_result=12'd2441 → after 2 edges, units=1, tens=4, hundreds=4, thousands=2.
  - Over one frame, segments shows 7'h79, 7'h19, 7'h19, 7'h24 in order.
- sum_result=567 → digits 7,6,5,0.
  - Thousands shows 7'h40, or 7'h7F when LEADING_ZERO_BLANK_EN is defined.
- sum_result=34 → digits 4,3,0,0.
- sum_result=5 → digits 5,0,0,0.
  - With LEADING_ZERO_BLANK_EN defined, only the units position is lit.
- sum_result=4095 → digits 5,9,0,4.
- Reset asserted mid-frame while index=2 → select returns to 4'b1110 after release. Each digit is then held for exactly 4 cycles.
